// File: rtl/bip_control_unit.sv
// ---------------------------------------------------------------------------
// bip_control_unit
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the BIP accumulator machine.
// It owns the PC and the instruction register, and it drives the datapath
// controls and the data-memory strobes.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   i_enable          run enable; when low, sequencing holds and strobes are off
//   i_instruction     program memory read data (sync ROM, one cycle after o_pc)
//   o_pc              program memory address
//   o_operand         IR operand field (datapath immediate / data-memory address)
//   o_sel_a           accumulator source: 0 mem, 1 operand_ext, 2 alu
//   o_sel_b           ALU B source: 1 operand_ext, 0 mem
//   o_write_acc       accumulator write strobe
//   o_operation       0 add, 1 subtract
//   o_rd_ram/o_wr_ram data memory read / write strobes
//   o_halted          HLT has executed
//   o_cycle_count     saturating count of active (enabled, non-halted) cycles
// ---------------------------------------------------------------------------
module bip_control_unit #(
    parameter int unsigned PC_BITS      = 11,
    parameter int unsigned OPCODE_BITS  = 5,
    parameter int unsigned OPERAND_BITS = 11,
    parameter int unsigned INSTR_BITS   = 16,
    parameter int unsigned CNT_BITS     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic [INSTR_BITS-1:0]   i_instruction,
    output logic [PC_BITS-1:0]      o_pc,
    output logic [OPERAND_BITS-1:0] o_operand,
    output logic [1:0]              o_sel_a,
    output logic                    o_sel_b,
    output logic                    o_write_acc,
    output logic                    o_operation,
    output logic                    o_rd_ram,
    output logic                    o_wr_ram,
    output logic                    o_halted,
    output logic [CNT_BITS-1:0]     o_cycle_count
);

    localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(5'b00000);
    localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(5'b00001);
    localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(5'b00010);
    localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(5'b00011);
    localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(5'b00100);
    localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5'b00101);
    localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(5'b00110);
    localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(5'b00111);

    localparam logic [1:0] SEL_MEM = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PC_BITS-1:0]      pc;
    logic [INSTR_BITS-1:0]   ir;
    logic [CNT_BITS-1:0]     cycle_count;
    logic [OPCODE_BITS-1:0]  fetch_opcode;
    logic [OPCODE_BITS-1:0]  ir_opcode;

    assign fetch_opcode = i_instruction[INSTR_BITS-1:OPERAND_BITS];
    assign ir_opcode    = ir[INSTR_BITS-1:OPERAND_BITS];

    // State register; i_enable low freezes the sequence in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else if (i_enable) begin
            state <= state_next;
        end
    end

    // Next-state logic; DECODE branches on the live ROM word, not the IR.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                if (fetch_opcode == OP_HLT) begin
                    state_next = HALT;
                end else if (fetch_opcode == OP_LD || fetch_opcode == OP_ADD ||
                             fetch_opcode == OP_SUB) begin
                    state_next = MEM;
                end else begin
                    state_next = EXEC;
                end
            end
            MEM:    state_next = EXEC;
            EXEC:   state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // PC and IR; PC advances once per completed EXEC and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else if (i_enable) begin
            if (state == DECODE) begin
                ir <= i_instruction;
            end
            if (state == EXEC) begin
                pc <= pc + PC_BITS'(1);
            end
        end
    end

    // Active-cycle counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (i_enable && state != HALT && cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_BITS'(1);
        end
    end

    // Output decode; strobes are gated by i_enable so a stalled EXEC fires once.
    always_comb begin
        o_sel_a     = SEL_MEM;
        o_sel_b     = 1'b0;
        o_write_acc = 1'b0;
        o_operation = 1'b0;
        o_rd_ram    = 1'b0;
        o_wr_ram    = 1'b0;
        case (state)
            MEM:  o_rd_ram = i_enable;
            EXEC: begin
                case (ir_opcode)
                    OP_STO:  o_wr_ram = i_enable;
                    OP_LD:   begin
                        o_write_acc = i_enable;
                        o_sel_a     = SEL_MEM;
                    end
                    OP_LDI:  begin
                        o_write_acc = i_enable;
                        o_sel_a     = SEL_IMM;
                    end
                    OP_ADD:  begin
                        o_write_acc = i_enable;
                        o_sel_a     = SEL_ALU;
                    end
                    OP_ADDI: begin
                        o_write_acc = i_enable;
                        o_sel_a     = SEL_ALU;
                        o_sel_b     = 1'b1;
                    end
                    OP_SUB:  begin
                        o_write_acc = i_enable;
                        o_sel_a     = SEL_ALU;
                        o_operation = 1'b1;
                    end
                    OP_SUBI: begin
                        o_write_acc = i_enable;
                        o_sel_a     = SEL_ALU;
                        o_sel_b     = 1'b1;
                        o_operation = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign o_pc          = pc;
    assign o_operand     = ir[OPERAND_BITS-1:0];
    assign o_halted      = (state == HALT);
    assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;

    localparam logic [4:0] HLT = 5'b00000, STO = 5'b00001, LD = 5'b00010, LDI = 5'b00011;
    localparam logic [4:0] ADD = 5'b00100, ADDI = 5'b00101, SUB = 5'b00110, SUBI = 5'b00111;
    localparam logic [4:0] NOP = 5'b11111;

    typedef struct {
        int          cyc;
        logic [17:0] ctrl;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst, en, ram_init, rst_w;
    logic [15:0] instr, instr_w;
    logic [10:0] pc, operand, operand_w;
    logic [2:0]  pc_w;
    logic [1:0]  sel_a, sel_a_w;
    logic        sel_b, write_acc, operation, rd_ram, wr_ram, halted;
    logic        sel_b_w, write_acc_w, operation_w, rd_ram_w, wr_ram_w, halted_w;
    logic [31:0] cycle_count, cycle_count_w;

    logic [15:0] rom [0:2047];
    logic [15:0] rom_w [0:7];
    logic [15:0] ram [0:2047];
    logic [15:0] acc, ram_q, ext, alu_b;
    logic [17:0] ctrl;
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        wa_prev  = 1'b0;
    ev_t         ev_q[$];
    logic [15:0] acc_q[$];

    always #5 clk = ~clk;

    bip_control_unit u_dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_instruction(instr),
        .o_pc(pc), .o_operand(operand), .o_sel_a(sel_a), .o_sel_b(sel_b),
        .o_write_acc(write_acc), .o_operation(operation), .o_rd_ram(rd_ram),
        .o_wr_ram(wr_ram), .o_halted(halted), .o_cycle_count(cycle_count)
    );

    bip_control_unit #(.PC_BITS(3)) u_wrap (
        .clk(clk), .rst(rst_w), .i_enable(1'b1), .i_instruction(instr_w),
        .o_pc(pc_w), .o_operand(operand_w), .o_sel_a(sel_a_w), .o_sel_b(sel_b_w),
        .o_write_acc(write_acc_w), .o_operation(operation_w), .o_rd_ram(rd_ram_w),
        .o_wr_ram(wr_ram_w), .o_halted(halted_w), .o_cycle_count(cycle_count_w)
    );

    // Synchronous program memories
    always @(posedge clk) instr   <= rom[pc];
    always @(posedge clk) instr_w <= rom_w[pc_w];

    // Accumulator datapath and data memory
    assign ext   = 16'(operand);
    assign alu_b = sel_b ? ext : ram_q;
    always @(posedge clk) begin
        if (ram_init) begin
            ram[4] <= 16'd10;
            ram[7] <= 16'd0;
            acc    <= 16'd0;
            ram_q  <= 16'd0;
        end else begin
            if (wr_ram) ram[operand] <= acc;
            if (rd_ram) ram_q <= ram[operand];
            if (write_acc) begin
                case (sel_a)
                    2'd0:    acc <= ram_q;
                    2'd1:    acc <= ext;
                    default: acc <= operation ? acc - alu_b : acc + alu_b;
                endcase
            end
        end
    end

    // Cycle numbering: cycle 1 is the first cycle after reset release
    always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

    assign ctrl = {rd_ram, wr_ram, write_acc, sel_a, sel_b, operation, operand};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: strobes pop expected events, acc checked one cycle after a write
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            wa_prev = 1'b0;
        end else begin
            if (wa_prev) begin
                if (acc_q.size() == 0) check("acc_extra", 64'(acc_q.size()), 64'(1));
                else check("acc", 64'(acc), 64'(acc_q.pop_front()));
            end
            wa_prev = write_acc;
            if (write_acc || wr_ram || rd_ram) begin
                if (ev_q.size() == 0) begin
                    check("strobe_extra", 64'(ctrl), 64'(0));
                end else begin
                    e = ev_q.pop_front();
                    check("ev_cycle", 64'(cyc), 64'(e.cyc));
                    check("ev_ctrl", 64'(ctrl), 64'(e.ctrl));
                end
            end
        end
    end

    function automatic logic [15:0] ins(input logic [4:0] op, input int opd);
        return {op, 11'(opd)};
    endfunction

    task automatic exp_ev(input int c, input logic rd, input logic wr, input logic wa,
                          input logic [1:0] sa, input logic sb, input logic op, input int opd);
        ev_t e;
        e.cyc  = c;
        e.ctrl = {rd, wr, wa, sa, sb, op, 11'(opd)};
        ev_q.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 64'(pc), 64'(0));
        check({tag, "_ctrl"}, 64'(ctrl), 64'(0));
        check({tag, "_halted"}, 64'(halted), 64'(0));
        check({tag, "_count"}, 64'(cycle_count), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1; ram_init = 1'b1; en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; ram_init = 1'b0;
        ev_q.delete();
        acc_q.delete();
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", 64'(halted), 64'(1));
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_ev_left"}, 64'(ev_q.size()), 64'(0));
        check({tag, "_acc_left"}, 64'(acc_q.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1; en = 1'b1; ram_init = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("por");

        // Immediate program with store and halt
        clear_rom();
        rom[0] = ins(LDI, 5); rom[1] = ins(ADDI, 3); rom[2] = ins(SUBI, 1);
        rom[3] = ins(STO, 7); rom[4] = ins(HLT, 0);
        do_reset();
        exp_ev(3, 0, 0, 1, 2'd1, 0, 0, 5);  acc_q.push_back(16'd5);
        exp_ev(6, 0, 0, 1, 2'd2, 1, 0, 3);  acc_q.push_back(16'd8);
        exp_ev(9, 0, 0, 1, 2'd2, 1, 1, 1);  acc_q.push_back(16'd7);
        exp_ev(12, 0, 1, 0, 2'd0, 0, 0, 7);
        wait_halt(40);
        check("t1_count", 64'(cycle_count), 64'(14));
        repeat (4) @(negedge clk);
        check("t1_count_frozen", 64'(cycle_count), 64'(14));
        check("t1_halted", 64'(halted), 64'(1));
        check("t1_ram7", 64'(ram[7]), 64'(7));
        check_drained("t1");

        // Memory operands
        clear_rom();
        rom[0] = ins(LD, 4); rom[1] = ins(ADD, 4); rom[2] = ins(SUB, 4); rom[3] = ins(HLT, 0);
        do_reset();
        exp_ev(3, 1, 0, 0, 2'd0, 0, 0, 4);
        exp_ev(4, 0, 0, 1, 2'd0, 0, 0, 4);  acc_q.push_back(16'd10);
        exp_ev(7, 1, 0, 0, 2'd0, 0, 0, 4);
        exp_ev(8, 0, 0, 1, 2'd2, 0, 0, 4);  acc_q.push_back(16'd20);
        exp_ev(11, 1, 0, 0, 2'd0, 0, 0, 4);
        exp_ev(12, 0, 0, 1, 2'd2, 0, 1, 4); acc_q.push_back(16'd10);
        wait_halt(40);
        check("t2_count", 64'(cycle_count), 64'(14));
        check_drained("t2");

        // Enable stall across an ADDI EXEC
        clear_rom();
        rom[0] = ins(LDI, 2); rom[1] = ins(ADDI, 3); rom[2] = ins(HLT, 0);
        do_reset();
        exp_ev(3, 0, 0, 1, 2'd1, 0, 0, 2);  acc_q.push_back(16'd2);
        exp_ev(11, 0, 0, 1, 2'd2, 1, 0, 3); acc_q.push_back(16'd5);
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_wa", 64'(write_acc), 64'(0));
            check("stall_pc", 64'(pc), 64'(1));
            check("stall_count", 64'(cycle_count), 64'(5));
        end
        @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 check("stall_pc_after", 64'(pc), 64'(2));
        wait_halt(40);
        check("t3_count", 64'(cycle_count), 64'(8));
        check_drained("t3");

        // Unknown opcode behaves as NOP
        clear_rom();
        rom[0] = ins(NOP, 9); rom[1] = ins(LDI, 9); rom[2] = ins(HLT, 0);
        do_reset();
        exp_ev(6, 0, 0, 1, 2'd1, 0, 0, 9);  acc_q.push_back(16'd9);
        repeat (3) @(posedge clk);
        #1 check("nop_pc", 64'(pc), 64'(1));
        wait_halt(40);
        check("t4_count", 64'(cycle_count), 64'(8));
        check_drained("t4");

        // Reset during MEM of LD aborts it
        clear_rom();
        rom[0] = ins(LD, 4); rom[1] = ins(HLT, 0);
        do_reset();
        exp_ev(3, 1, 0, 0, 2'd0, 0, 0, 4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1; ram_init = 1'b1;
        #1 check_reset_outputs("abort");
        check("abort_operand", 64'(operand), 64'(0));
        check("abort_ev_left", 64'(ev_q.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; ram_init = 1'b0;
        check("abort_pc_restart", 64'(pc), 64'(0));
        exp_ev(3, 1, 0, 0, 2'd0, 0, 0, 4);
        exp_ev(4, 0, 0, 1, 2'd0, 0, 0, 4);  acc_q.push_back(16'd10);
        wait_halt(40);
        check("t5_count", 64'(cycle_count), 64'(6));
        check_drained("t5");

        // 3-bit PC wraps after eight NOPs and refetches address 0
        rom_w[0] = ins(NOP, 11'h55);
        for (int k = 1; k < 8; k++) rom_w[k] = ins(NOP, k);
        @(posedge clk);
        #1 rst_w = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            check("wrap_quiet", 64'({rd_ram_w, wr_ram_w, write_acc_w, sel_a_w, sel_b_w, operation_w, halted_w}), 64'(0));
            if (c == 22) check("wrap_pc7", 64'(pc_w), 64'(7));
            if (c == 24) check("wrap_operand7", 64'(operand_w), 64'(7));
            if (c == 25) check("wrap_pc0", 64'(pc_w), 64'(0));
            if (c == 27) begin
                check("wrap_refetch", 64'(operand_w), 64'(11'h55));
                check("wrap_count", 64'(cycle_count_w), 64'(26));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Multi-cycle instruction sequencer for the BIP accumulator datapath.
- Owns the program counter and instruction register.
- Fetches 16-bit instructions from a synchronous program memory and decodes the 5-bit opcode.
- Drives the datapath controls (sel_a, sel_b, write_acc, operation) and the data-memory read/write strobes. Sits between program memory, data memory and the datapath in the BIP top level.

Parameters:
PC_BITS, 11, program counter width (program memory address)
OPCODE_BITS, 5, opcode field width, instruction bits [INSTR_BITS-1 : OPERAND_BITS]
OPERAND_BITS, 11, operand field width, instruction bits [OPERAND_BITS-1:0]
INSTR_BITS, 16, instruction width; must equal OPCODE_BITS+OPERAND_BITS
CNT_BITS, 32, cycle counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
i_enable  in  1  run enable; 0 freezes sequencing
i_instruction  in  INSTR_BITS  program memory read data, valid one cycle after o_pc is sampled
o_pc  out  PC_BITS  program memory address
o_operand  out  OPERAND_BITS  IR operand field, to datapath and data-memory address
o_sel_a  out  2  accumulator source: 0 = mem, 1 = operand_ext, 2 = alu
o_sel_b  out  1  ALU B source: 1 = operand_ext, 0 = mem
o_write_acc  out  1  accumulator write strobe
o_operation  out  1  0 = add, 1 = subtract
o_rd_ram  out  1  data memory read strobe
o_wr_ram  out  1  data memory write strobe; accumulator is the write data
o_halted  out  1  HLT executed
o_cycle_count  out  CNT_BITS  active cycles executed

Behaviour:
- Reset (async, any state):
  - state=FETCH; PC=0; IR=0; o_halted=0; o_cycle_count=0.
  - All strobes 0; o_sel_a=0; o_sel_b=0; o_operation=0.
- Opcodes:
  - HLT 00000, STO 00001, LD 00010, LDI 00011.
  - ADD 00100, ADDI 00101, SUB 00110, SUBI 00111.
  - Any other opcode is a NOP.
- States: FETCH, DECODE, MEM, EXEC, HALT.
  - FETCH: o_pc=PC presented to program memory; next state DECODE.
  - DECODE: IR <= i_instruction. Opcode taken from i_instruction:
    - HLT -> HALT.
    - LD/ADD/SUB -> MEM.
    - All others -> EXEC.
  - MEM: o_rd_ram=1, address=o_operand; read data is valid during the next cycle; next state EXEC.
  - EXEC: assert controls for exactly one cycle; PC <= PC+1; next state FETCH.
  - HALT: all strobes 0, o_halted=1; terminal until rst.
- EXEC control decode (unlisted controls are 0):
  - STO: o_wr_ram=1.
  - LD: write_acc=1, sel_a=0.
  - LDI: write_acc=1, sel_a=1.
  - ADD: write_acc=1, sel_a=2, sel_b=0, op=0.
  - ADDI: write_acc=1, sel_a=2, sel_b=1, op=0.
  - SUB: write_acc=1, sel_a=2, sel_b=0, op=1.
  - SUBI: write_acc=1, sel_a=2, sel_b=1, op=1.
  - NOP: no strobes; PC still increments.
- Strobes outside EXEC/MEM are 0. o_sel_a, o_sel_b and o_operation are 0 outside EXEC.
- o_operand = IR operand field, stable from the cycle after DECODE until the next DECODE.
- Latency: immediate/STO/NOP take 3 cycles; LD/ADD/SUB take 4. The accumulator updates at the EXEC closing edge.
- PC wraps from 2^PC_BITS-1 to 0; there is no trap on wrap.
- i_enable=0:
  - State, PC, IR and counter hold.
  - o_write_acc, o_wr_ram and o_rd_ram are forced 0.
  - An EXEC stalled by i_enable completes exactly once when i_enable returns.
  - A stall in DECODE re-samples i_instruction on resume. Program memory holds its output because o_pc is unchanged.
- o_cycle_count increments every clk with i_enable=1 and state≠HALT; it saturates at all-ones.
- Reset asserted mid-instruction aborts it: no partial strobe, and the PC restarts at 0.

Test Plan:
- Program LDI 5; ADDI 3; SUBI 1; STO 7; HLT -> o_wr_ram pulses once with o_operand=7 in cycle 12; HALT entered in cycle 14 (count from cycle 1); o_cycle_count=14 and frozen; o_halted=1.
- RAM[4]=10, program LD 4; ADD 4; SUB 4 -> each instruction has o_rd_ram=1 in MEM with o_operand=4, then EXEC with sel_a=0 / (sel_a=2, sel_b=0, op=0) / (sel_a=2, sel_b=0, op=1); accumulator sequence 10, 20, 10.
- Drop i_enable for 5 cycles during an ADDI EXEC -> o_write_acc=0 throughout the stall, exactly one o_write_acc pulse after resume, PC advances by 1, count excludes the 5 stall cycles.
- Opcode 11111 -> no strobes, PC increments, next instruction executes normally.
- Assert rst during the MEM state of LD -> outputs zero immediately; o_pc=0 after release; no o_write_acc pulse for the aborted LD.
- PC_BITS=3 with 8 NOPs then the program wraps -> o_pc sequence 7 then 0, and instruction 0 is refetched.
